// File: rtl/alu_uart_interface_if.sv
// Handshake/bus bundle between the UART byte stream, the ALU and alu_uart_interface.
// slave = the interface block itself, master = its environment (UART + ALU).
interface alu_uart_interface_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 6
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_done;
  logic              tx_done;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;

  modport slave (
    input  rx_data, rx_done, tx_done, alu_result,
    output alu_a, alu_b, alu_op, tx_data, tx_start
  );

  modport master (
    output rx_data, rx_done, tx_done, alu_result,
    input  alu_a, alu_b, alu_op, tx_data, tx_start
  );
endinterface

// File: rtl/alu_uart_interface.sv
// Collects A, B, opcode bytes from the UART receiver, drives the ALU, and sends the result back.
// Optional partial-frame timeout enabled by defining ALU_IF_TIMEOUT_EN.
module alu_uart_interface #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 6
`ifdef ALU_IF_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
`endif
) (
  input logic                  clk,
  input logic                  reset,
  alu_uart_interface_if.slave  bus
);

  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, CALC, WAIT_TX} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_start_q;
  logic              expired;

`ifdef ALU_IF_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q;
  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= GET_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
`ifdef ALU_IF_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        GET_A: begin
          if (bus.rx_done) begin
            a_q     <= bus.rx_data;
            state_q <= GET_B;
          end
        end
        GET_B: begin
          if (bus.rx_done) begin
            b_q     <= bus.rx_data;
            state_q <= GET_OP;
          end else if (expired) begin
            state_q <= GET_A;
          end
        end
        GET_OP: begin
          if (bus.rx_done) begin
            op_q    <= bus.rx_data[OP_W-1:0];
            state_q <= CALC;
          end else if (expired) begin
            state_q <= GET_A;
          end
        end
        // One cycle for the ALU to settle on the freshly registered operands.
        CALC: begin
          tx_data_q  <= bus.alu_result;
          tx_start_q <= 1'b1;
          state_q    <= WAIT_TX;
        end
        WAIT_TX: begin
          if (bus.tx_done) begin
            state_q <= GET_A;
          end
        end
        default: state_q <= GET_A;
      endcase
`ifdef ALU_IF_TIMEOUT_EN
      // Counts idle cycles inside a partial frame; any byte or frame restart clears it.
      if ((state_q == GET_B || state_q == GET_OP) && !bus.rx_done && !expired) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
`endif
    end
  end

  assign bus.alu_a    = a_q;
  assign bus.alu_b    = b_q;
  assign bus.alu_op   = op_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Self-checking bench for alu_uart_interface: directed test-plan steps plus random frames
// checked against a byte-queue reference model; timeout steps compile in with ALU_IF_TIMEOUT_EN.
module tb_alu_uart_interface;

  localparam int unsigned DW = 8;
  localparam int unsigned OW = 6;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  alu_uart_interface_if #(.DATA_W(DW), .OP_W(OW)) bus ();

`ifdef ALU_IF_TIMEOUT_EN
  alu_uart_interface #(.DATA_W(DW), .OP_W(OW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`else
  alu_uart_interface #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural TP1 ALU sitting on the DUT outputs.
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> b;
      6'h03:   return sa >>> b;
      default: return 8'h00;
    endcase
  endfunction

  assign bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);

  // Reference model: bytes accumulate into a frame unless a result is pending.
  logic [7:0] pending[$];
  bit         m_busy;
  logic [7:0] exp_a, exp_b, exp_tx;
  logic [5:0] exp_op;

  task automatic model_reset();
    pending.delete();
    m_busy = 0;
    exp_a  = 8'h00;
    exp_b  = 8'h00;
    exp_op = 6'h00;
    exp_tx = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit with_txdone);
    if (m_busy) begin
      if (with_txdone) m_busy = 0;
    end else begin
      pending.push_back(b);
      if (pending.size() == 1) exp_a = b;
      if (pending.size() == 2) exp_b = b;
      if (pending.size() == 3) begin
        exp_op = b[5:0];
        exp_tx = alu_fn(exp_a, exp_b, exp_op);
        m_busy = 1;
        pending.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_a"},  32'(bus.alu_a),  32'(exp_a));
    chk({tag, "_b"},  32'(bus.alu_b),  32'(exp_b));
    chk({tag, "_op"}, 32'(bus.alu_op), 32'(exp_op));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_txdone);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    bus.tx_done = with_txdone;
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    bus.rx_data = 8'($urandom);
    model_byte(b, with_txdone);
  endtask

  task automatic pulse_txdone();
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    m_busy = 0;
  endtask

  task automatic do_reset(input int unsigned n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Sends A, B, opcode back to back and checks the one-cycle tx_start pulse two edges later.
  task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a, 0);
    send_byte(b, 0);
    send_byte(op, 0);
    chk_regs(tag);
    chk({tag, "_ts_early"}, 32'(bus.tx_start), 32'd0);
    @(negedge clk);
    chk({tag, "_ts"}, 32'(bus.tx_start), 32'd1);
    chk({tag, "_tx"}, 32'(bus.tx_data), 32'(exp_tx));
    @(negedge clk);
    chk({tag, "_ts_late"}, 32'(bus.tx_start), 32'd0);
  endtask

  initial begin
    logic [7:0] ops[8];
    logic [7:0] opb;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    model_reset();

    // Reset held two cycles with a byte pending: reset wins.
    reset = 1'b1;
    bus.rx_done = 1'b1;
    bus.rx_data = 8'h55;
    bus.tx_done = 1'b1;
    repeat (2) @(negedge clk);
    chk_regs("rst");
    chk("rst_tx", 32'(bus.tx_data), 32'd0);
    chk("rst_ts", 32'(bus.tx_start), 32'd0);
    reset = 1'b0;
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    send_byte(8'h11, 0);
    chk("rst_first_a", 32'(bus.alu_a), 32'h11);
    chk("rst_first_b", 32'(bus.alu_b), 32'h00);
    do_reset(1);

    // NOR frame.
    frame("nor", 8'h0F, 8'hF0, 8'h27);
    chk("nor_a_c", 32'(bus.alu_a), 32'h0F);
    chk("nor_b_c", 32'(bus.alu_b), 32'hF0);
    chk("nor_op_c", 32'(bus.alu_op), 32'h27);
    chk("nor_tx_c", 32'(bus.tx_data), 32'h00);
    pulse_txdone();

    // Back-to-back ADD then SUB; a byte before tx_done is dropped.
    frame("add", 8'h05, 8'h03, 8'h20);
    chk("add_tx_c", 32'(bus.tx_data), 32'h08);
    send_byte(8'h99, 0);
    chk("add_hold_a", 32'(bus.alu_a), 32'h05);
    pulse_txdone();
    frame("sub", 8'h05, 8'h07, 8'h22);
    chk("sub_tx_c", 32'(bus.tx_data), 32'hFE);

    // Byte coincident with tx_done in WAIT_TX is dropped.
    send_byte(8'hAA, 1);
    chk("drop_a", 32'(bus.alu_a), 32'h05);
    frame("and", 8'h01, 8'h02, 8'h24);
    chk("and_tx_c", 32'(bus.tx_data), 32'h00);
    pulse_txdone();

    // Opcode truncation.
    frame("trunc", 8'h0F, 8'h3C, 8'hE5);
    chk("trunc_op_c", 32'(bus.alu_op), 32'h25);
    chk("trunc_tx_c", 32'(bus.tx_data), 32'h3F);

    // tx_done outside WAIT_TX ignored (stale tx_done after reset, and mid-frame).
    do_reset(1);
    chk_regs("rst_wait");
    pulse_txdone();
    send_byte(8'h40, 0);
    pulse_txdone();
    send_byte(8'h04, 0);
    chk_regs("txd_ignored");
    send_byte(8'h02, 0);
    chk("srl_op", 32'(bus.alu_op), 32'h02);
    @(negedge clk);
    chk("srl_ts", 32'(bus.tx_start), 32'd1);
    chk("srl_tx", 32'(bus.tx_data), 32'h04);
    pulse_txdone();

    // Reset mid-frame discards A and B.
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    do_reset(1);
    chk_regs("rst_mid");
    frame("fresh", 8'h01, 8'h02, 8'h25);
    chk("fresh_tx_c", 32'(bus.tx_data), 32'h03);
    pulse_txdone();

`ifdef ALU_IF_TIMEOUT_EN
    // Byte on the expiry edge wins.
    send_byte(8'h21, 0);
    repeat (14) @(negedge clk);
    send_byte(8'h10, 0);
    chk_regs("to_edge");
    send_byte(8'h26, 0);
    @(negedge clk);
    chk("to_edge_tx", 32'(bus.tx_data), 32'h31);
    pulse_txdone();
    // A only, 16 idle cycles -> back in GET_A.
    send_byte(8'h77, 0);
    repeat (15) @(negedge clk);
    pending.delete();
    frame("to_xor", 8'h0C, 8'h0A, 8'h26);
    chk("to_xor_tx_c", 32'(bus.tx_data), 32'h06);
    pulse_txdone();
`else
    // Partial frame waits indefinitely.
    send_byte(8'h0C, 0);
    repeat (40) @(negedge clk);
    send_byte(8'h0A, 0);
    send_byte(8'h26, 0);
    @(negedge clk);
    chk("wait_ts", 32'(bus.tx_start), 32'd1);
    chk("wait_tx", 32'(bus.tx_data), 32'h06);
    pulse_txdone();
`endif

    // Random frames with gaps, dropped bytes and coincident tx_done.
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 3; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        opb = ops[$urandom_range(0, 7)] | 8'($urandom_range(0, 3) << 6);
        send_byte((k == 2) ? opb : 8'($urandom), 0);
        chk_regs("rnd");
      end
      @(negedge clk);
      chk("rnd_ts", 32'(bus.tx_start), 32'd1);
      chk("rnd_tx", 32'(bus.tx_data), 32'(exp_tx));
      repeat ($urandom_range(0, 2)) send_byte(8'($urandom), 0);
      if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 1);
      else pulse_txdone();
      chk_regs("rnd_post");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
